barramento_snooping: RTL and testbench

- Shared snooping-bus controller between NPROC per-processor MSI coherence machines and main memory.
- Consumes each actuating machine's bus message (saidaBarramento) and each listening machine's writeBack/abortAccessMemory.
- Arbitrates round-robin, broadcasts one message at a time and collects snoop replies.
- Sources the data either from an aborting owner (also written back to memory) or from memory, then returns it to the requester.

---
 rtl/barramento_snooping.sv | 182 ++++++++++++++++++
 tb/tb_barramento_snooping.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/barramento_snooping.sv
// Shared snooping-bus controller for NPROC MSI caches: round-robin arbitration,
// message broadcast, snoop-reply collection and owner-or-memory data sourcing.
module barramento_snooping #(
    parameter int unsigned NPROC   = 3,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [NPROC-1:0]        req,
    input  logic [2*NPROC-1:0]      msg_in,
    input  logic [ADDR_W*NPROC-1:0] addr_in,
    input  logic [NPROC-1:0]        snoop_wb,
    input  logic [NPROC-1:0]        snoop_abort,
    input  logic [DATA_W*NPROC-1:0] snoop_data,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic [NPROC-1:0]        gnt,
    output logic                    bus_valid,
    output logic [1:0]              bus_msg,
    output logic [ADDR_W-1:0]       bus_addr,
    output logic [NPROC-1:0]        bus_src,
    output logic                    mem_rd,
    output logic                    mem_wr,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    output logic                    resp_valid,
    output logic [DATA_W-1:0]       resp_data,
    output logic [NPROC-1:0]        resp_dst,
    output logic                    busy
);
    localparam int unsigned PW = (NPROC > 1) ? $clog2(NPROC) : 1;
    localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [1:0] MSG_INV  = 2'b00;
    localparam logic [1:0] MSG_NONE = 2'b11;

    typedef enum logic [2:0] {OCIOSO, DIFUNDE, ESCUTA, GRAVA, LE, RESPONDE} state_t;

    state_t            state, state_d;
    logic [PW-1:0]     ptr, ptr_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic [1:0]        msg_q, msg_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [NPROC-1:0]  gnt_d;

    logic [NPROC-1:0]  elig;
    logic              found;
    logic [PW-1:0]     win;
    int unsigned       idx;

    // Round-robin search over eligible requesters, starting at the pointer
    always_comb begin
        elig  = '0;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NPROC; i++) begin
            elig[i] = req[i] && (msg_in[2*i +: 2] != MSG_NONE);
        end
        for (int unsigned k = 0; k < NPROC; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NPROC) idx = idx - NPROC;
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    logic [NPROC-1:0]  owner_req;
    logic [DATA_W-1:0] owner_data;
    logic              taken;

    // Only abort selects an owner; a writeBack without abort is ignored
    always_comb begin
        owner_req  = snoop_abort & (snoop_wb | snoop_abort) & ~gnt;
        owner_data = '0;
        taken      = 1'b0;
        for (int unsigned i = 0; i < NPROC; i++) begin
            if (owner_req[i] && !taken) begin
                owner_data = snoop_data[i*DATA_W +: DATA_W];
                taken      = 1'b1;
            end
        end
    end

    // Next-state and latched-transaction logic
    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        cnt_d   = cnt;
        msg_d   = msg_q;
        addr_d  = addr_q;
        data_d  = data_q;
        gnt_d   = gnt;
        case (state)
            OCIOSO: begin
                if (found) begin
                    state_d = DIFUNDE;
                    gnt_d   = NPROC'(1) << win;
                    msg_d   = msg_in[2*32'(win) +: 2];
                    addr_d  = addr_in[ADDR_W*32'(win) +: ADDR_W];
                    data_d  = '0;
                    ptr_d   = (win == PW'(NPROC-1)) ? '0 : PW'(win + 1'b1);
                end
            end
            DIFUNDE: state_d = (msg_q == MSG_INV) ? RESPONDE : ESCUTA;
            ESCUTA: begin
                cnt_d = CW'(MEM_LAT-1);
                if (|owner_req) begin
                    state_d = GRAVA;
                    data_d  = owner_data;
                end else begin
                    state_d = LE;
                end
            end
            GRAVA: begin
                if (cnt == '0) state_d = RESPONDE;
                else           cnt_d   = cnt - 1'b1;
            end
            LE: begin
                if (cnt == '0) begin
                    state_d = RESPONDE;
                    data_d  = mem_rdata;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            RESPONDE: begin
                state_d = OCIOSO;
                gnt_d   = '0;
            end
            default: state_d = OCIOSO;
        endcase
    end

    // State, transaction latches and registered outputs decoded from the next state
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= OCIOSO;
            ptr        <= '0;
            cnt        <= '0;
            msg_q      <= MSG_NONE;
            addr_q     <= '0;
            data_q     <= '0;
            gnt        <= '0;
            bus_src    <= '0;
            bus_valid  <= 1'b0;
            bus_msg    <= MSG_NONE;
            bus_addr   <= '0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_dst   <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            ptr        <= ptr_d;
            cnt        <= cnt_d;
            msg_q      <= msg_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            gnt        <= gnt_d;
            bus_src    <= gnt_d;
            bus_valid  <= (state_d == DIFUNDE);
            bus_msg    <= (state_d == DIFUNDE) ? msg_d : MSG_NONE;
            bus_addr   <= (state_d == DIFUNDE) ? addr_d : '0;
            mem_rd     <= (state_d == LE);
            mem_wr     <= (state_d == GRAVA);
            mem_addr   <= (state_d == LE || state_d == GRAVA) ? addr_d : '0;
            mem_wdata  <= (state_d == GRAVA) ? data_d : '0;
            resp_valid <= (state_d == RESPONDE);
            resp_data  <= (state_d == RESPONDE) ? data_d : '0;
            resp_dst   <= (state_d == RESPONDE) ? gnt_d : '0;
            busy       <= (state_d != OCIOSO);
        end
    end
endmodule

// File: tb/tb_barramento_snooping.sv
// Directed self-checking bench for barramento_snooping (NPROC=3, MEM_LAT=2).
`timescale 1ns/1ps
module tb_barramento_snooping;
    localparam int unsigned NPROC   = 3;
    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned MEM_LAT = 2;

    logic clock = 1'b0;
    logic resetn;
    logic [NPROC-1:0]        req;
    logic [2*NPROC-1:0]      msg_in;
    logic [ADDR_W*NPROC-1:0] addr_in;
    logic [NPROC-1:0]        snoop_wb, snoop_abort;
    logic [DATA_W*NPROC-1:0] snoop_data;
    logic [DATA_W-1:0]       mem_rdata;
    logic [NPROC-1:0]        gnt, bus_src, resp_dst;
    logic                    bus_valid, mem_rd, mem_wr, resp_valid, busy;
    logic [1:0]              bus_msg;
    logic [ADDR_W-1:0]       bus_addr, mem_addr;
    logic [DATA_W-1:0]       mem_wdata, resp_data;

    barramento_snooping #(.NPROC(NPROC), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
        .clock(clock), .resetn(resetn), .req(req), .msg_in(msg_in), .addr_in(addr_in),
        .snoop_wb(snoop_wb), .snoop_abort(snoop_abort), .snoop_data(snoop_data),
        .mem_rdata(mem_rdata), .gnt(gnt), .bus_valid(bus_valid), .bus_msg(bus_msg),
        .bus_addr(bus_addr), .bus_src(bus_src), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .resp_valid(resp_valid),
        .resp_data(resp_data), .resp_dst(resp_dst), .busy(busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Per-transaction observations gathered by observe()
    int         lat, n_bv, n_rd, n_wr;
    logic       got;
    logic [1:0] bv_msg;
    logic [3:0] bv_addr, mem_a;
    logic [2:0] bv_src, gnt_or, r_dst;
    logic [7:0] wr_data, r_data;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr_inputs();
        req = '0; msg_in = '1; addr_in = '0;
        snoop_wb = '0; snoop_abort = '0; snoop_data = '0;
    endtask

    task automatic set_req(input int p, input logic [1:0] m, input logic [3:0] a);
        req[p] = 1'b1;
        msg_in[2*p +: 2] = m;
        addr_in[4*p +: 4] = a;
    endtask

    task automatic observe(input int max_cyc);
        lat = 0; n_bv = 0; n_rd = 0; n_wr = 0; got = 1'b0; gnt_or = '0;
        bv_msg = '0; bv_addr = '0; bv_src = '0; mem_a = '0; wr_data = '0; r_dst = '0; r_data = '0;
        for (int c = 0; c < max_cyc && !got; c++) begin
            tick();
            lat++;
            gnt_or |= gnt;
            if (bus_valid) begin n_bv++; bv_msg = bus_msg; bv_addr = bus_addr; bv_src = bus_src; end
            if (mem_rd) begin n_rd++; mem_a = mem_addr; end
            if (mem_wr) begin n_wr++; mem_a = mem_addr; wr_data = mem_wdata; end
            if (resp_valid) begin got = 1'b1; r_dst = resp_dst; r_data = resp_data; end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; clr_inputs(); mem_rdata = '0;
        tick(); tick();
        checks++; if ({gnt, bus_valid, bus_addr, bus_src, mem_rd, mem_wr, mem_addr, mem_wdata,
                       resp_valid, resp_data, resp_dst, busy} !== '0)
            begin errors++; $display("FAIL reset_outputs got %h exp 0", {gnt, bus_valid, bus_addr,
                  bus_src, mem_rd, mem_wr, mem_addr, mem_wdata, resp_valid, resp_data, resp_dst, busy}); end
        checks++; if (bus_msg !== 2'b11) begin errors++; $display("FAIL reset_bus_msg got %b exp 11", bus_msg); end
        resetn = 1'b1;
        tick();
        checks++; if (busy !== 1'b0 || gnt !== 3'b000)
            begin errors++; $display("FAIL reset_idle busy=%b gnt=%b exp 0/000", busy, gnt); end
    endtask

    task automatic test_read_miss();
        mem_rdata = 8'hA5;
        set_req(0, 2'b01, 4'd5);
        tick();
        checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL rm_gnt got %b exp 001", gnt); end
        checks++; if (bus_valid !== 1'b1) begin errors++; $display("FAIL rm_bus_valid got %b exp 1", bus_valid); end
        checks++; if (bus_msg !== 2'b01) begin errors++; $display("FAIL rm_bus_msg got %b exp 01", bus_msg); end
        checks++; if (bus_addr !== 4'd5) begin errors++; $display("FAIL rm_bus_addr got %0d exp 5", bus_addr); end
        checks++; if (bus_src !== 3'b001) begin errors++; $display("FAIL rm_bus_src got %b exp 001", bus_src); end
        // requester changes its inputs mid-transaction; latched values must win
        addr_in[3:0] = 4'd9; msg_in[1:0] = 2'b10;
        observe(20);
        checks++; if (!got) begin errors++; $display("FAIL rm_resp_timeout got none exp resp_valid"); end
        checks++; if (lat + 1 != 5) begin errors++; $display("FAIL rm_latency got %0d exp 5", lat + 1); end
        checks++; if (n_rd != 2) begin errors++; $display("FAIL rm_mem_rd_cycles got %0d exp 2", n_rd); end
        checks++; if (n_wr != 0) begin errors++; $display("FAIL rm_mem_wr_cycles got %0d exp 0", n_wr); end
        checks++; if (mem_a !== 4'd5) begin errors++; $display("FAIL rm_mem_addr got %0d exp 5", mem_a); end
        checks++; if (r_dst !== 3'b001) begin errors++; $display("FAIL rm_resp_dst got %b exp 001", r_dst); end
        checks++; if (r_data !== 8'hA5) begin errors++; $display("FAIL rm_resp_data got %h exp a5", r_data); end
        clr_inputs();
        tick();
        checks++; if ({busy, gnt, resp_valid, bus_msg} !== 7'b0_000_0_11)
            begin errors++; $display("FAIL rm_back_idle got %b exp 0000011", {busy, gnt, resp_valid, bus_msg}); end
    endtask

    task automatic test_write_miss_owner();
        mem_rdata = 8'hA5;
        set_req(1, 2'b10, 4'd3);
        snoop_abort = 3'b100; snoop_wb = 3'b100;
        snoop_data = {8'h3C, 8'h77, 8'h11};
        observe(20);
        checks++; if (!got) begin errors++; $display("FAIL wm_resp_timeout got none exp resp_valid"); end
        checks++; if (lat != 5) begin errors++; $display("FAIL wm_latency got %0d exp 5", lat); end
        checks++; if (n_bv != 1 || bv_msg !== 2'b10 || bv_addr !== 4'd3 || bv_src !== 3'b010)
            begin errors++; $display("FAIL wm_broadcast got n=%0d msg=%b addr=%0d src=%b exp 1/10/3/010",
                  n_bv, bv_msg, bv_addr, bv_src); end
        checks++; if (n_wr != 2) begin errors++; $display("FAIL wm_mem_wr_cycles got %0d exp 2", n_wr); end
        checks++; if (wr_data !== 8'h3C || mem_a !== 4'd3)
            begin errors++; $display("FAIL wm_mem_write got data=%h addr=%0d exp 3c/3", wr_data, mem_a); end
        checks++; if (n_rd != 0) begin errors++; $display("FAIL wm_mem_rd_cycles got %0d exp 0", n_rd); end
        checks++; if (r_dst !== 3'b010 || r_data !== 8'h3C)
            begin errors++; $display("FAIL wm_resp got dst=%b data=%h exp 010/3c", r_dst, r_data); end
        clr_inputs();
        tick();
    endtask

    task automatic test_invalidate();
        mem_rdata = 8'hFF;
        set_req(2, 2'b00, 4'd7);
        observe(10);
        checks++; if (!got) begin errors++; $display("FAIL inv_resp_timeout got none exp resp_valid"); end
        checks++; if (lat != 2) begin errors++; $display("FAIL inv_latency got %0d exp 2", lat); end
        checks++; if (n_bv != 1 || bv_msg !== 2'b00 || bv_addr !== 4'd7 || bv_src !== 3'b100)
            begin errors++; $display("FAIL inv_broadcast got n=%0d msg=%b addr=%0d src=%b exp 1/00/7/100",
                  n_bv, bv_msg, bv_addr, bv_src); end
        checks++; if (n_rd != 0 || n_wr != 0)
            begin errors++; $display("FAIL inv_mem_idle got rd=%0d wr=%0d exp 0/0", n_rd, n_wr); end
        checks++; if (r_dst !== 3'b100 || r_data !== 8'h00)
            begin errors++; $display("FAIL inv_resp got dst=%b data=%h exp 100/00", r_dst, r_data); end
        clr_inputs();
        tick();
    endtask

    task automatic test_round_robin();
        logic [2:0] order [4];
        int   nresp;
        logic prev_resp;
        nresp = 0; prev_resp = 1'b0;
        for (int i = 0; i < 4; i++) order[i] = '0;
        mem_rdata = 8'h42;
        set_req(0, 2'b01, 4'd1); set_req(1, 2'b01, 4'd2); set_req(2, 2'b01, 4'd4);
        for (int c = 0; c < 80 && nresp < 4; c++) begin
            tick();
            if (prev_resp) begin
                checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL rr_idle_gap got gnt=%b exp 000", gnt); end
            end
            prev_resp = resp_valid;
            if (resp_valid) begin
                order[nresp] = resp_dst;
                nresp++;
                if (nresp == 4) req = '0;
            end
        end
        checks++; if (nresp != 4) begin errors++; $display("FAIL rr_count got %0d exp 4", nresp); end
        checks++; if (order[0] !== 3'b001 || order[1] !== 3'b010 || order[2] !== 3'b100 || order[3] !== 3'b001)
            begin errors++; $display("FAIL rr_order got %b %b %b %b exp 001 010 100 001",
                  order[0], order[1], order[2], order[3]); end
        clr_inputs();
        tick();
    endtask

    task automatic test_masked_abort();
        logic [2:0] idle_gnt;
        mem_rdata = 8'h5A;
        set_req(0, 2'b01, 4'd6);
        set_req(1, 2'b11, 4'd2);
        snoop_abort = 3'b001; snoop_wb = 3'b101;
        snoop_data = {8'hEE, 8'hDD, 8'hCC};
        observe(20);
        checks++; if (!got) begin errors++; $display("FAIL ma_resp_timeout got none exp resp_valid"); end
        checks++; if (lat != 5) begin errors++; $display("FAIL ma_latency got %0d exp 5", lat); end
        checks++; if (n_rd != 2 || n_wr != 0)
            begin errors++; $display("FAIL ma_path got rd=%0d wr=%0d exp 2/0", n_rd, n_wr); end
        checks++; if (r_dst !== 3'b001 || r_data !== 8'h5A)
            begin errors++; $display("FAIL ma_resp got dst=%b data=%h exp 001/5a", r_dst, r_data); end
        checks++; if (gnt_or !== 3'b001) begin errors++; $display("FAIL ma_gnt_seen got %b exp 001", gnt_or); end
        req[0] = 1'b0;
        snoop_abort = '0; snoop_wb = '0;
        idle_gnt = '0;
        for (int c = 0; c < 6; c++) begin tick(); idle_gnt |= gnt; end
        checks++; if (idle_gnt !== 3'b000 || busy !== 1'b0)
            begin errors++; $display("FAIL ma_none_granted got gnt=%b busy=%b exp 000/0", idle_gnt, busy); end
        clr_inputs();
        tick();
    endtask

    task automatic test_reset_mid_grava();
        logic seen;
        seen = 1'b0;
        set_req(1, 2'b10, 4'd3);
        snoop_abort = 3'b100; snoop_wb = 3'b100;
        snoop_data = {8'h3C, 8'h00, 8'h00};
        for (int c = 0; c < 10 && !seen; c++) begin tick(); seen = mem_wr; end
        checks++; if (!seen) begin errors++; $display("FAIL rg_reach_grava got no mem_wr exp mem_wr"); end
        #2;
        resetn = 1'b0;
        #1;
        checks++; if ({gnt, bus_valid, bus_addr, bus_src, mem_rd, mem_wr, mem_addr, mem_wdata,
                       resp_valid, resp_data, resp_dst, busy} !== '0 || bus_msg !== 2'b11)
            begin errors++; $display("FAIL rg_async_clear got %h msg=%b exp 0/11", {gnt, bus_valid, bus_addr,
                  bus_src, mem_rd, mem_wr, mem_addr, mem_wdata, resp_valid, resp_data, resp_dst, busy}, bus_msg); end
        clr_inputs();
        tick();
        resetn = 1'b1;
        mem_rdata = 8'h99;
        set_req(0, 2'b01, 4'd8);
        set_req(2, 2'b01, 4'd9);
        observe(20);
        checks++; if (!got) begin errors++; $display("FAIL rg_resp_timeout got none exp resp_valid"); end
        checks++; if (r_dst !== 3'b001) begin errors++; $display("FAIL rg_pointer got dst=%b exp 001", r_dst); end
        checks++; if (lat != 5 || r_data !== 8'h99 || mem_a !== 4'd8)
            begin errors++; $display("FAIL rg_resp got lat=%0d data=%h addr=%0d exp 5/99/8", lat, r_data, mem_a); end
        clr_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_write_miss_owner();
        test_invalidate();
        test_round_robin();
        test_masked_abort();
        test_reset_mid_grava();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
